// File: rtl/token_out.sv
// token_out: serialises a USB-style token packet (PID, address, endpoint,
// CRC5) as SYNC, bit-stuffed data and EOP on a single-bit line.
module token_out #(
  parameter int STUFF_LIMIT = 6,
  parameter int EOP_LEN     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  pid_type,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
  output logic        ready,
  output logic [23:0] pkt_word,
  output logic        tx_bit,
  output logic        tx_en,
  output logic        tx_eop,
  output logic        done,
  output logic        err
);

  localparam int                ONES_W    = $clog2(STUFF_LIMIT + 1);
  localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(STUFF_LIMIT - 1);
  localparam logic [7:0]        EOP_LAST  = 8'(EOP_LEN - 1);
  localparam logic [7:0]        SYNC_LAST = 8'd7;
  localparam logic [7:0]        DATA_LAST = 8'd23;
  localparam logic [7:0]        DATA_END  = 8'd24;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP} state_t;

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;     // position within SYNC, DATA or EOP
  logic [ONES_W-1:0] ones, ones_n;   // run length of transmitted 1s
  logic [23:0]       pkt_n;
  logic              done_n, err_n;
  logic              data_bit;
  logic              pid_ok;

  // CRC5 over 11 bits, MSB first, generator x^5+x^2+1, zero seed, no inversion.
  function automatic logic [4:0] crc5_d11(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = '0;
    for (int i = 10; i >= 0; i--) begin
      // NOTE: blocking assignments are correct here: this is a combinational
      // loop evaluated in one step, not state held across clock edges.
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  assign pid_ok   = (pid_type inside {4'b1001, 4'b0001, 4'b1101, 4'b0101});
  assign data_bit = (cnt <= DATA_LAST) ? pkt_word[5'd23 - cnt[4:0]] : 1'b0;

  // Next-state, datapath updates and line outputs for the transmit sequence.
  always_comb begin
    // NOTE: every signal written below gets a default first so that no path
    // through the case statement leaves one unassigned and infers a latch.
    state_n = state;
    cnt_n   = cnt;
    ones_n  = ones;
    pkt_n   = pkt_word;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ready   = 1'b0;
    tx_bit  = 1'b0;
    tx_en   = 1'b0;
    tx_eop  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (pid_ok) begin
            pkt_n   = {~pid_type, pid_type, addr, endp, crc5_d11({addr, endp})};
            state_n = SYNC;
            cnt_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SYNC: begin
        tx_en  = 1'b1;
        tx_bit = (cnt == SYNC_LAST);
        cnt_n  = cnt + 8'd1;
        if (cnt == SYNC_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
          ones_n  = '0;
        end
      end
      DATA: begin
        tx_en  = 1'b1;
        tx_bit = data_bit;
        cnt_n  = cnt + 8'd1;
        ones_n = data_bit ? ones + ONES_W'(1) : '0;
        if (data_bit && (ones == ONES_LAST)) begin
          // cnt_n already points at the next unsent bit (24 means none left).
          state_n = STUFF;
          ones_n  = '0;
        end else if (cnt == DATA_LAST) begin
          state_n = EOP;
          cnt_n   = '0;
        end
      end
      STUFF: begin
        tx_en  = 1'b1;
        ones_n = '0;
        if (cnt == DATA_END) begin
          state_n = EOP;
          cnt_n   = '0;
        end else begin
          state_n = DATA;
        end
      end
      EOP: begin
        tx_en  = 1'b1;
        tx_eop = 1'b1;
        cnt_n  = cnt + 8'd1;
        if (cnt == EOP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ones     <= '0;
      pkt_word <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ones     <= ones_n;
      pkt_word <= pkt_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_token_out.sv
// tb_token_out: randomized and directed checks of token_out against a
// queue-based model of the SYNC / stuffed data / EOP line sequence.
module tb_token_out;

  localparam int STUFF_LIMIT = 6;
  localparam int EOP_LEN     = 2;
  localparam int MAX_CYC     = 63;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  pid_type;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic        ready;
  logic [23:0] pkt_word;
  logic        tx_bit, tx_en, tx_eop, done, err;

  int total = 0;
  int bad   = 0;

  token_out #(.STUFF_LIMIT(STUFF_LIMIT), .EOP_LEN(EOP_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .pid_type(pid_type),
    .addr(addr), .endp(endp), .ready(ready), .pkt_word(pkt_word),
    .tx_bit(tx_bit), .tx_en(tx_en), .tx_eop(tx_eop), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remainder of d(x)*x^5 divided by x^5+x^2+1 (polynomial long division).
  function automatic logic [4:0] crc_ref(input logic [10:0] d);
    logic [15:0] v;
    v = {d, 5'b00000};
    for (int b = 15; b >= 5; b--)
      if (v[b]) v = v ^ (16'b100101 << (b - 5));
    return v[4:0];
  endfunction

  function automatic logic [23:0] exp_word(input logic [3:0] p, input logic [6:0] a,
                                           input logic [3:0] e);
    return {~p, p, a, e, crc_ref({a, e})};
  endfunction

  // Expected line sequence: SYNC, data with a 0 after every run of
  // STUFF_LIMIT ones, then EOP_LEN EOP cycles.
  task automatic build_expected(input logic [23:0] w, output int len,
                                output logic [63:0] bits, output logic [63:0] eops);
    bit q[$];
    int run;
    q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run = 0;
    for (int i = 23; i >= 0; i--) begin
      q.push_back(w[i]);
      run = w[i] ? run + 1 : 0;
      if (run == STUFF_LIMIT) begin
        q.push_back(1'b0);
        run = 0;
      end
    end
    bits = '0;
    eops = '0;
    for (int i = 0; i < q.size(); i++) bits[i] = q[i];
    for (int i = 0; i < EOP_LEN; i++) eops[q.size() + i] = 1'b1;
    len = q.size() + EOP_LEN;
  endtask

  // Called on the negedge of the first cycle after acceptance; records the
  // line until done rises or the cycle budget runs out.
  task automatic capture(output int n, output logic [63:0] bits,
                         output logic [63:0] ens, output logic [63:0] eops);
    n = 0; bits = '0; ens = '0; eops = '0;
    while (!done && n < MAX_CYC) begin
      bits[n] = tx_bit;
      ens[n]  = tx_en;
      eops[n] = tx_eop;
      n++;
      @(negedge clk);
    end
  endtask

  // Receiver view: strip SYNC, drop stuffed bits, then validate like token_in.
  task automatic rx_check(input logic [63:0] bits, input int n, input logic [23:0] exp,
                          input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    logic [23:0] w;
    int k, run;
    w = '0; k = 0; run = 0;
    for (int i = 8; i < n && k < 24; i++) begin
      if (run == STUFF_LIMIT) begin
        run = 0;
      end else begin
        w[23 - k] = bits[i];
        k++;
        run = bits[i] ? run + 1 : 0;
      end
    end
    check("destuffed", 64'(w), 64'(exp));
    check("rx_err", 64'((crc_ref(w[15:5]) != w[4:0]) || (w[23:20] != ~w[19:16])), 64'd0);
    check("rx_fields", 64'({w[19:16], w[15:9], w[8:5]}), 64'({p, a, e}));
  endtask

  task automatic check_stream(input logic [23:0] w, input logic [3:0] p,
                              input logic [6:0] a, input logic [3:0] e);
    int n, len;
    logic [63:0] bits, ens, eops, xbits, xeops;
    build_expected(w, len, xbits, xeops);
    capture(n, bits, ens, eops);
    check("cycles_to_done", 64'(n), 64'(len));
    check("tx_bits", bits, xbits);
    check("tx_en", ens, (64'd1 << len) - 64'd1);
    check("tx_eop", eops, xeops);
    check("done_pulse", 64'(done), 64'd1);
    check("ready_on_done", 64'(ready), 64'd1);
    rx_check(bits, n, w, p, a, e);
  endtask

  task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    logic [23:0] w;
    w = exp_word(p, a, e);
    @(negedge clk);
    check("ready_before", 64'(ready), 64'd1);
    start = 1'b1; pid_type = p; addr = a; endp = e;
    @(negedge clk);
    start = 1'b0;
    check("pkt_word", 64'(pkt_word), 64'(w));
    check_stream(w, p, a, e);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [3:0]  pids [4];
    logic [23:0] w, prev;
    int seen;
    pids = '{4'b1001, 4'b0001, 4'b1101, 4'b0101};
    reset = 1'b1; start = 1'b0; pid_type = '0; addr = '0; endp = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_lines", 64'({tx_bit, tx_en, tx_eop}), 64'd0);
    check("rst_pulses", 64'({done, err}), 64'd0);
    check("rst_pkt", 64'(pkt_word), 64'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; pid_type = 4'b1001;
    @(negedge clk);
    check("rst_prio", 64'({ready, tx_en, pkt_word}), 64'({1'b1, 1'b0, 24'h0}));
    start = 1'b0; reset = 1'b0;

    // IN, addr 0, endp 0.
    send(4'b1001, 7'h00, 4'h0);
    check("in_word", 64'(pkt_word), 64'h690000);

    // SETUP, all-ones address/endpoint exercises stuffing.
    send(4'b1101, 7'h7F, 4'hF);
    check("setup_pid", 64'(pkt_word[23:16]), 64'h2D);

    // Invalid PID: error pulse, nothing sent, word untouched.
    prev = pkt_word;
    @(negedge clk);
    start = 1'b1; pid_type = 4'b0011; addr = 7'h15; endp = 4'h2;
    @(negedge clk);
    start = 1'b0;
    check("bad_err", 64'(err), 64'd1);
    check("bad_txen", 64'(tx_en), 64'd0);
    check("bad_ready", 64'(ready), 64'd1);
    check("bad_pkt", 64'(pkt_word), 64'(prev));
    @(negedge clk);
    check("bad_err_clear", 64'({err, tx_en}), 64'd0);

    // Start held high: one packet, then a second accepted on the done cycle.
    w = exp_word(4'b0001, 7'h12, 4'h3);
    start = 1'b1; pid_type = 4'b0001; addr = 7'h12; endp = 4'h3;
    @(negedge clk);
    check_stream(w, 4'b0001, 7'h12, 4'h3);
    @(negedge clk);
    check("held_restart", 64'({ready, tx_en}), 64'({1'b0, 1'b1}));
    start = 1'b0;
    check_stream(w, 4'b0001, 7'h12, 4'h3);
    @(negedge clk);

    // Reset on the 10th data bit aborts without done.
    start = 1'b1; pid_type = 4'b0101; addr = 7'h2A; endp = 4'h9;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", 64'({tx_en, ready, pkt_word}), 64'({1'b0, 1'b1, 24'h0}));
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Random valid tokens, biased toward long runs of ones.
    for (int i = 0; i < 100; i++) begin
      logic [3:0] p;
      logic [6:0] a;
      logic [3:0] e;
      p = pids[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) < 3) begin
        a = 7'h7F; e = 4'($urandom);
      end else begin
        a = 7'($urandom); e = 4'($urandom);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(p, a, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/token_out.md
TOKEN_OUT -- requirements
Module: token_out

Interface
REQ-001 SHALL have parameter STUFF_LIMIT, default 6: count of consecutive transmitted 1s that forces a stuffed 0.
REQ-002 SHALL have parameter EOP_LEN, default 2: number of EOP cycles.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request to send one token; qualified by ready.
REQ-006 SHALL have port pid_type  input  4: token PID nibble (IN 4'b1001, OUT 4'b0001, SETUP 4'b1101, SOF 4'b0101).
REQ-007 SHALL have port addr  input  7: device address.
REQ-008 SHALL have port endp  input  4: endpoint number.
REQ-009 SHALL have port ready  output  1: high only in IDLE.
REQ-010 SHALL have port pkt_word  output  24: registered packet word {pid byte, addr, endp, crc5}.
REQ-011 SHALL have port tx_bit  output  1: serial line bit.
REQ-012 SHALL have port tx_en  output  1: high while a bit or EOP is driven.
REQ-013 SHALL have port tx_eop  output  1: high during EOP cycles.
REQ-014 SHALL have port done  output  1: one-cycle pulse after the last EOP cycle.
REQ-015 SHALL have port err  output  1: one-cycle pulse on a rejected request.

Function
REQ-016 SHALL accept a request when start=1 and ready=1 at a clock edge; start with ready=0 SHALL be ignored, not queued.
REQ-017 SHALL reject a request whose pid_type is not one of the four token codes: err=1 for the following cycle, no transmission, remain IDLE.
REQ-018 SHALL, on acceptance, register pkt_word[23:16] = {~pid_type, pid_type}, [15:9] = addr, [8:5] = endp, [4:0] = crc5.
REQ-019 SHALL compute crc5 as the CRC5_D11 next-state function of pkt_word[15:5], seed 5'b00000, generator x^5+x^2+1, no final inversion, bit-identical to the check in token_in.
REQ-020 SHALL hold pkt_word stable from acceptance until the next accepted request.
REQ-021 SHALL implement states IDLE -> SYNC -> DATA (<-> STUFF) -> EOP -> IDLE.
REQ-022 SHALL in SYNC drive 8 bits 0,0,0,0,0,0,0,1 with tx_en=1; the first SYNC bit is on the cycle after acceptance.
REQ-023 SHALL in DATA drive pkt_word MSB-first (bit 23 first, bit 0 last), one bit per cycle, tx_en=1.
REQ-024 SHALL keep a ones counter, cleared on entry to DATA (SYNC bits not counted), incremented on each transmitted 1, cleared on each transmitted 0.
REQ-025 SHALL, when the counter reaches STUFF_LIMIT, enter STUFF for one cycle driving tx_bit=0, clear the counter, then resume with the next unsent data bit.
REQ-026 SHALL stuff after bit 0 if bit 0 completes a run of STUFF_LIMIT ones, before entering EOP.
REQ-027 SHALL in EOP drive tx_bit=0, tx_en=1, tx_eop=1 for EOP_LEN cycles.
REQ-028 SHALL pulse done for the first IDLE cycle after EOP; ready=1 in that same cycle.
REQ-029 SHALL make the transmit time from acceptance to done = 8 + 24 + stuffed bits + EOP_LEN cycles.
REQ-030 SHALL drive tx_bit=0, tx_en=0, tx_eop=0 in IDLE.

Reset
REQ-031 SHALL, with reset=1 at an edge, enter IDLE regardless of state (including mid-SYNC, DATA, STUFF or EOP), aborting any packet without EOP.
REQ-032 SHALL set reset values ready=1, tx_bit=0, tx_en=0, tx_eop=0, done=0, err=0, pkt_word=24'h000000, ones counter=0.
REQ-033 SHALL give reset priority over start in the same cycle.

Verification
REQ-034 SHALL cover IN, addr=0, endp=0: pkt_word=24'h690000; serial 00000001 then 011010010000000000000000, then 2 EOP cycles; done 34 cycles after acceptance.
REQ-035 SHALL cover SETUP, addr=7'h7F, endp=4'hF: pkt_word[23:16]=8'h2D, crc5 matches CRC5_D11; a 0 is inserted after each run of 6 ones; token_in fed pkt_word reports err=0, addr=7'h7F, endp=4'hF.
REQ-036 SHALL cover pid_type=4'b0011: err pulses one cycle, tx_en stays 0, ready stays 1, pkt_word unchanged.
REQ-037 SHALL cover start held high across a transmission: exactly one packet is sent; a second is accepted on the done cycle.
REQ-038 SHALL cover reset asserted on the 10th DATA bit: the next cycle shows tx_en=0, ready=1, pkt_word=24'h000000, and no done pulse.
REQ-039 SHALL cover a loopback of 100 random valid tokens: token_in on pkt_word gives err=0 and matching pid/addr/endp; the de-stuffed serial stream equals pkt_word.
